// File: rtl/fpga_cfg_loader_if.sv
// Word-serial configuration stream between a bitstream source and the loader.
// Signals:
//   s_data  - bitstream word (WORD_W bits)
//   s_valid - word present on s_data
//   s_ready - loader accepts the word; a transfer is s_valid & s_ready
// Modports: master drives data/valid, slave (the loader) drives ready.
interface fpga_cfg_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fpga_cfg_loader.sv
// Fabric configuration loader. Receives a header word, NWORDS payload words and an XOR
// checksum word over a valid/ready stream, unpacks the payload into a staging register and,
// only after a matching checksum, commits it atomically to the active select outputs.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   s (slave)       - bitstream stream (s_data/s_valid/s_ready)
//   abort           - drop any load in progress and return to idle
//   busy            - loader not idle
//   done            - one-cycle pulse, concurrent with newly committed outputs
//   error           - framing/checksum error, held until abort
//   cfg_loaded      - set on first commit
//   *select         - slices of the active configuration driving the fabric
// Optional feature (macro FPGA_CFG_READBACK_EN): rb_addr/rb_req/rb_data/rb_valid read one
// word of the active configuration, one cycle after the request.
module fpga_cfg_loader #(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned CFG_BITS = 2678,
  parameter logic [31:0] MAGIC    = 32'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  fpga_cfg_loader_if.slave     s,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 cfg_loaded,
  output logic [749:0]         brbselect,
  output logic [1727:0]        bsbselect,
  output logic [79:0]          lbselect,
  output logic [29:0]          leftioselect,
  output logic [29:0]          rightioselect,
  output logic [29:0]          topioselect,
  output logic [29:0]          bottomioselect
`ifdef FPGA_CFG_READBACK_EN
  ,
  input  logic [$clog2((CFG_BITS+WORD_W-1)/WORD_W)-1:0] rb_addr,
  input  logic                 rb_req,
  output logic [WORD_W-1:0]    rb_data,
  output logic                 rb_valid
`endif
);

  localparam int unsigned NWORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int unsigned CNT_W  = $clog2(NWORDS);
  localparam logic [WORD_W-1:0] MagicW = MAGIC[WORD_W-1:0];

  typedef enum logic [2:0] {StIdle, StLoad, StCrc, StCommit, StErr} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   csum_q, csum_d;
  logic [CFG_BITS-1:0] staging_q, staging_d;
  logic [CFG_BITS-1:0] active_q;
  logic                done_q, loaded_q;
  logic                commit;

  // Commit happens on the edge leaving StCommit unless abort cancels it.
  assign commit = (state_q == StCommit) && !abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    staging_d = staging_q;
    s.s_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        s.s_ready = 1'b1;
        if (s.s_valid) begin
          if (s.s_data == MagicW) begin
            state_d = StLoad;
            cnt_d   = '0;
            csum_d  = '0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StLoad: begin
        s.s_ready = 1'b1;
        if (s.s_valid) begin
          // Bits of the last word beyond CFG_BITS have no staging slot and fall away here.
          for (int unsigned i = 0; i < CFG_BITS; i++) begin
            if (cnt_q == CNT_W'(i / WORD_W)) staging_d[i] = s.s_data[i % WORD_W];
          end
          csum_d = csum_q ^ s.s_data;
          if (cnt_q == CNT_W'(NWORDS - 1)) state_d = StCrc;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StCrc: begin
        s.s_ready = 1'b1;
        if (s.s_valid) state_d = (s.s_data == csum_q) ? StCommit : StErr;
      end
      StCommit: state_d = StIdle;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      csum_q    <= '0;
      staging_q <= '0;
      active_q  <= '0;
      done_q    <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      staging_q <= staging_d;
      done_q    <= commit;
      if (commit) begin
        active_q <= staging_q;
        loaded_q <= 1'b1;
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign error      = (state_q == StErr);
  assign done       = done_q;
  assign cfg_loaded = loaded_q;

  assign brbselect      = active_q[749:0];
  assign bsbselect      = active_q[2477:750];
  assign lbselect       = active_q[2557:2478];
  assign leftioselect   = active_q[2587:2558];
  assign rightioselect  = active_q[2617:2588];
  assign topioselect    = active_q[2647:2618];
  assign bottomioselect = active_q[2677:2648];

`ifdef FPGA_CFG_READBACK_EN
  logic [WORD_W-1:0] rb_word;
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_valid_q;

  // Zero-pads above CFG_BITS and for addresses past the last word.
  always_comb begin
    rb_word = '0;
    for (int unsigned j = 0; j < WORD_W; j++) begin
      if ((32'(rb_addr) * WORD_W + j) < CFG_BITS) begin
        rb_word[j] = active_q[32'(rb_addr) * WORD_W + j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= rb_req;
      rb_data_q  <= rb_req ? rb_word : '0;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: a table of whole-load scenarios, hand-written
// abort/reset/back-to-back sequences and randomized loads, checked against a word-array model
// of the active configuration.
module tb_fpga_cfg_loader;
  localparam int NW = 335;
  localparam int CB = 2678;

  logic clk = 1'b0;
  logic rst, abort;
  always #5 clk = ~clk;

  fpga_cfg_loader_if #(.WORD_W(8)) bus ();

  logic          busy, done, error, cfg_loaded;
  logic [749:0]  brbselect;
  logic [1727:0] bsbselect;
  logic [79:0]   lbselect;
  logic [29:0]   leftioselect, rightioselect, topioselect, bottomioselect;
`ifdef FPGA_CFG_READBACK_EN
  logic [8:0] rb_addr;
  logic       rb_req;
  logic [7:0] rb_data;
  logic       rb_valid;
`endif

  fpga_cfg_loader dut (
    .clk            (clk),
    .rst            (rst),
    .s              (bus),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .cfg_loaded     (cfg_loaded),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect)
`ifdef FPGA_CFG_READBACK_EN
    ,
    .rb_addr        (rb_addr),
    .rb_req         (rb_req),
    .rb_data        (rb_data),
    .rb_valid       (rb_valid)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] ld_words[NW];     // words of the load being sent
  logic [7:0] model_words[NW];  // words of the configuration expected to be active
  bit         model_loaded;

  typedef struct {
    logic [7:0] hdr;
    int         pat;
    logic [7:0] flip;
    bit         stall;
    bit         exp_ok;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [CB-1:0] model_cfg();
    logic [CB-1:0] v;
    for (int i = 0; i < CB; i++) v[i] = model_words[i / 8][i % 8];
    return v;
  endfunction

  function automatic logic [CB-1:0] dut_cfg();
    return {bottomioselect, topioselect, rightioselect, leftioselect, lbselect, bsbselect,
            brbselect};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic check_cfg(input string name);
    logic [CB-1:0] g, w;
    int first;
    g = dut_cfg();
    w = model_cfg();
    checks++;
    if (g !== w) begin
      failures++;
      first = 0;
      for (int i = CB - 1; i >= 0; i--) if (g[i] !== w[i]) first = i;
      $display("FAIL %s cfg bit %0d got=%b want=%b", name, first, g[first], w[first]);
    end
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < NW; k++) begin
      case (pat)
        0:       ld_words[k] = 8'(k);
        1:       ld_words[k] = 8'hFF;
        2:       ld_words[k] = 8'($urandom);
        default: ld_words[k] = 8'h00;
      endcase
    end
  endtask

  // Entered and left at a negedge; the transfer happens on the posedge in between.
  task automatic send_word(input logic [7:0] w, input bit stall);
    int n;
    if (stall) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=ready0 want=ready1 word=%0h", w);
      bus.s_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic run_load(input logic [7:0] hdr, input bit stall, input logic [7:0] flip);
    logic [7:0] cs;
    cs = 8'h00;
    send_word(hdr, stall);
    if (hdr !== 8'hA5) begin
      bus.s_valid = 1'b0;
      return;
    end
    for (int k = 0; k < NW; k++) begin
      send_word(ld_words[k], stall);
      cs ^= ld_words[k];
    end
    send_word(cs ^ flip, stall);
    bus.s_valid = 1'b0;
  endtask

  // Called at the negedge right after the last word of a load was transferred.
  task automatic post_check(input string tag, input bit ok);
    check({tag, "_no_early_done"}, 64'(done), 64'd0);
    check_cfg({tag, "_old_cfg_held"});
    @(negedge clk);
    if (ok) begin
      model_words  = ld_words;
      model_loaded = 1'b1;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_error"}, 64'(error), 64'd0);
    end else begin
      check({tag, "_no_done"}, 64'(done), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd1);
      check({tag, "_ready_in_err"}, 64'(bus.s_ready), 64'd0);
    end
    check({tag, "_busy"}, 64'(busy), 64'(!ok));
    check({tag, "_cfg_loaded"}, 64'(cfg_loaded), 64'(model_loaded));
    check_cfg({tag, "_cfg"});
    @(negedge clk);
    check({tag, "_done_single"}, 64'(done), 64'd0);
    if (!ok) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({tag, "_abort_error"}, 64'(error), 64'd0);
      check({tag, "_abort_ready"}, 64'(bus.s_ready), 64'd1);
      check({tag, "_abort_busy"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr, flip;
    bit         st;

    vecs[0] = '{hdr: 8'h5A, pat: 0, flip: 8'h00, stall: 1'b0, exp_ok: 1'b0};
    vecs[1] = '{hdr: 8'hA5, pat: 0, flip: 8'h00, stall: 1'b0, exp_ok: 1'b1};
    vecs[2] = '{hdr: 8'hA5, pat: 2, flip: 8'h01, stall: 1'b0, exp_ok: 1'b0};
    vecs[3] = '{hdr: 8'hA5, pat: 0, flip: 8'h00, stall: 1'b1, exp_ok: 1'b1};
    vecs[4] = '{hdr: 8'hA5, pat: 2, flip: 8'h00, stall: 1'b1, exp_ok: 1'b1};
    vecs[5] = '{hdr: 8'hA5, pat: 3, flip: 8'h00, stall: 1'b0, exp_ok: 1'b1};

    for (int k = 0; k < NW; k++) model_words[k] = 8'h00;
    model_loaded = 1'b0;
    rst = 1'b1;
    abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
`ifdef FPGA_CFG_READBACK_EN
    rb_addr = '0;
    rb_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", 64'(bus.s_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_loaded", 64'(cfg_loaded), 64'd0);
    check_cfg("rst_cfg");

    // Idle with no valid words: nothing consumed.
    repeat (5) @(negedge clk);
    check("idle_hold_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      fill(vecs[i].pat);
      run_load(vecs[i].hdr, vecs[i].stall, vecs[i].flip);
      post_check($sformatf("vec%0d", i), vecs[i].exp_ok);
      if (vecs[i].exp_ok && vecs[i].pat == 0) begin
        check($sformatf("vec%0d_brb_15_8", i), 64'(brbselect[15:8]), 64'h01);
        check($sformatf("vec%0d_bottomio_hi", i), 64'(bottomioselect[29:28]),
              64'(ld_words[334][5:4]));
      end
    end

    // Abort while word 100 is being transferred, then a full all-ones load.
    fill(1);
    send_word(8'hA5, 1'b0);
    for (int k = 0; k < 100; k++) send_word(ld_words[k], 1'b0);
    bus.s_data = ld_words[100];
    bus.s_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.s_valid = 1'b0;
    check("abort_load_busy", 64'(busy), 64'd0);
    check("abort_load_done", 64'(done), 64'd0);
    check_cfg("abort_load_cfg");
    @(negedge clk);
    check("abort_load_done2", 64'(done), 64'd0);
    run_load(8'hA5, 1'b0, 8'h00);
    post_check("ff_load", 1'b1);
    check("ff_all_ones", 64'(&dut_cfg()), 64'd1);

    // Abort in the commit cycle cancels the commit.
    fill(2);
    run_load(8'hA5, 1'b0, 8'h00);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_commit_done", 64'(done), 64'd0);
    check("abort_commit_busy", 64'(busy), 64'd0);
    check_cfg("abort_commit_cfg");
    @(negedge clk);
    check("abort_commit_done2", 64'(done), 64'd0);

    // Back-to-back: next header offered in the idle cycle right after commit.
    fill(2);
    run_load(8'hA5, 1'b0, 8'h00);
    check("b2b_commit_cycle_done", 64'(done), 64'd0);
    @(negedge clk);
    model_words = ld_words;
    check("b2b_first_done", 64'(done), 64'd1);
    check_cfg("b2b_first_cfg");
    fill(0);
    run_load(8'hA5, 1'b0, 8'h00);
    post_check("b2b_second", 1'b1);

    // Randomized loads: occasional bad header, stalls and checksum corruption.
    for (int r = 0; r < 4; r++) begin
      fill(2);
      hdr  = ($urandom % 4 == 0) ? 8'($urandom_range(0, 164)) : 8'hA5;
      st   = 1'($urandom % 2);
      flip = ($urandom % 2 == 1) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
      run_load(hdr, st, flip);
      post_check($sformatf("rnd%0d", r), (hdr == 8'hA5) && (flip == 8'h00));
    end

    // Make sure a non-zero config is active before the reset test.
    fill(1);
    run_load(8'hA5, 1'b0, 8'h00);
    post_check("pre_rst", 1'b1);

    // Asynchronous reset asserted between edges in the middle of a load.
    fill(2);
    send_word(8'hA5, 1'b0);
    for (int k = 0; k < 50; k++) send_word(ld_words[k], 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NW; k++) model_words[k] = 8'h00;
    model_loaded = 1'b0;
    check("arst_done", 64'(done), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    check("arst_loaded", 64'(cfg_loaded), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check_cfg("arst_cfg");
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_ready", 64'(bus.s_ready), 64'd1);

    fill(0);
    run_load(8'hA5, 1'b0, 8'h00);
    post_check("post_rst", 1'b1);

`ifdef FPGA_CFG_READBACK_EN
    rb_addr = 9'd1;
    rb_req = 1'b1;
    @(negedge clk);
    rb_req = 1'b0;
    check("rb_valid", 64'(rb_valid), 64'd1);
    check("rb_word1", 64'(rb_data), 64'(model_words[1]));
    rb_addr = 9'd334;
    rb_req = 1'b1;
    @(negedge clk);
    rb_req = 1'b0;
    check("rb_word334", 64'(rb_data), 64'(model_words[334] & 8'h3F));
    rb_addr = 9'd400;
    rb_req = 1'b1;
    @(negedge clk);
    rb_req = 1'b0;
    check("rb_oob", 64'(rb_data), 64'd0);
    @(negedge clk);
    check("rb_valid_low", 64'(rb_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
